// File: rtl/debug_pkg.sv
// Constants shared by the debug link: snapshot geometry, frame header byte and
// the transmitter's state encodings.
package debug_pkg;

  localparam int DATA_W  = 1376;
  localparam int N_BYTES = DATA_W / 8;
  localparam int CNT_W   = 8;

  localparam logic [CNT_W-1:0] N_BYTES_C = CNT_W'(N_BYTES);
  localparam logic [7:0]       HEADER    = 8'hA5;

  // IDLE is all-zero; every active state owns one bit.
  localparam logic [4:0] ST_IDLE = 5'b00000;
  localparam logic [4:0] ST_HDR  = 5'b00001;
  localparam logic [4:0] ST_DATA = 5'b00010;
  localparam logic [4:0] ST_WAIT = 5'b00100;
  localparam logic [4:0] ST_CHK  = 5'b01000;
  localparam logic [4:0] ST_DONE = 5'b10000;

endpackage

// File: rtl/debug_frame_tx.sv
// Debug link transmitter: captures a datapath snapshot on start and streams it to
// the UART as header, LSB-first data bytes and an XOR checksum of the data bytes.
module debug_frame_tx
  import debug_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] DataPath_bus,
  input  logic              tx_done_tick,
  output logic              tx_write,
  output logic [7:0]        tx_bus,
  output logic              busy,
  output logic              done
);

  logic [4:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        chk;
  logic              chk_sent;
  logic [DATA_W-1:0] snap;
  logic [7:0]        cur_byte;

  assign cur_byte = snap[{cnt, 3'b000} +: 8];

  // Outputs are loaded on the transition into HDR/DATA/CHK/DONE so that each
  // tx_write pulse lines up with the state that owns it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      chk      <= '0;
      chk_sent <= 1'b0;
      snap     <= '0;
      tx_write <= 1'b0;
      tx_bus   <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            snap     <= DataPath_bus;
            cnt      <= '0;
            chk      <= '0;
            chk_sent <= 1'b0;
            tx_write <= 1'b1;
            tx_bus   <= HEADER;
            busy     <= 1'b1;
            state    <= ST_HDR;
          end
        end
        ST_HDR, ST_DATA, ST_CHK: begin
          tx_write <= 1'b0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done_tick) begin
            if (cnt < N_BYTES_C) begin
              tx_write <= 1'b1;
              tx_bus   <= cur_byte;
              chk      <= chk ^ cur_byte;
              cnt      <= cnt + 1'b1;
              state    <= ST_DATA;
            end else if (!chk_sent) begin
              tx_write <= 1'b1;
              tx_bus   <= chk;
              chk_sent <= 1'b1;
              state    <= ST_CHK;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          tx_write <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Bench for debug_frame_tx: a UART model with configurable tick delay checks every
// transmitted byte against a queue of expected frame bytes.
module tb_debug_frame_tx;
  import debug_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] bus;
  logic              tx_done_tick;
  logic              tx_write;
  logic [7:0]        tx_bus;
  logic              busy;
  logic              done;

  logic uart_tick  = 1'b0;
  logic wr_stray   = 1'b0;
  logic idle_stray = 1'b0;
  assign tx_done_tick = uart_tick | wr_stray | idle_stray;

  always #5 clk = ~clk;

  debug_frame_tx dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .DataPath_bus (bus),
    .tx_done_tick (tx_done_tick),
    .tx_write     (tx_write),
    .tx_bus       (tx_bus),
    .busy         (busy),
    .done         (done)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         writes = 0;
  int         tick_delay = 1;
  bit         stray_on_write = 1'b0;
  int         cnt_uart = 0;

  typedef struct {
    logic [DATA_W-1:0] bus;
    int                delay;
    logic [7:0]        chk;
    bit                stray;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] xor_bytes(input logic [DATA_W-1:0] d);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < N_BYTES; i++) x ^= d[8*i +: 8];
    return x;
  endfunction

  // UART model and byte scoreboard
  always @(negedge clk) begin
    uart_tick = 1'b0;
    wr_stray  = 1'b0;
    if (cnt_uart > 0) begin
      cnt_uart--;
      if (cnt_uart == 0) uart_tick = 1'b1;
    end
    if (tx_write === 1'b1) begin
      writes++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_write: tx_bus %0h written, no byte expected", tx_bus);
      end else begin
        check("tx_byte", {24'h0, tx_bus}, {24'h0, exp_q.pop_front()});
      end
      cnt_uart = tick_delay;
      if (stray_on_write) wr_stray = 1'b1;
    end
  end

  task automatic push_frame(input logic [DATA_W-1:0] d, input logic [7:0] c);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < N_BYTES; i++) exp_q.push_back(d[8*i +: 8]);
    exp_q.push_back(c);
  endtask

  task automatic send_start(input logic [DATA_W-1:0] d, input logic [7:0] c);
    @(posedge clk);
    #1;
    start = 1'b1;
    bus   = d;
    push_frame(d, c);
    writes = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("hdr_write", tx_write, 1);
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, ok, 1);
    if (ok) begin
      check({name, "_writes"}, writes, 174);
      check({name, "_queue_left"}, exp_q.size(), 0);
      check({name, "_busy_in_done"}, busy, 1);
    end
  endtask

  task automatic check_fall(input string name);
    @(negedge clk);
    check({name, "_busy_fall"}, busy, 0);
    check({name, "_done_pulse"}, done, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    reset = 1'b1;
    start = 1'b0;
    bus   = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_write", tx_write, 0);
    check("rst_tx_bus", tx_bus, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    v = '0;
    for (int i = 0; i < N_BYTES; i++) v[8*i +: 8] = 8'(i);
    tbl[0] = '{bus: v, delay: 1, chk: 8'h00, stray: 1'b0};
    tbl[1] = '{bus: '1, delay: 1, chk: 8'h00, stray: 1'b0};
    for (int i = 0; i < N_BYTES; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
    tbl[2] = '{bus: v, delay: 3, chk: xor_bytes(v), stray: 1'b0};
    v = '0;
    v[DATA_W-1 -: 8] = 8'h5A;
    tbl[3] = '{bus: v, delay: 10, chk: 8'h5A, stray: 1'b1};
    v = '0;
    v[7:0] = 8'h01;
    v[DATA_W-1 -: 8] = 8'h80;
    tbl[4] = '{bus: v, delay: 2, chk: 8'h81, stray: 1'b0};

    for (int k = 0; k < 5; k++) begin
      tick_delay     = tbl[k].delay;
      stray_on_write = 1'b0;
      if (tbl[k].stray) begin
        @(negedge clk) idle_stray = 1'b1;
        @(negedge clk) idle_stray = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_stray_write", tx_write, 0);
        check("idle_stray_busy", busy, 0);
        stray_on_write = 1'b1;
      end
      send_start(tbl[k].bus, tbl[k].chk);
      wait_done($sformatf("vec%0d", k));
      check_fall($sformatf("vec%0d", k));
    end
    stray_on_write = 1'b0;

    // Capture isolation: bus cleared after start, second start mid-frame
    tick_delay = 1;
    send_start(tbl[0].bus, 8'h00);
    bus = '0;
    repeat (40) @(posedge clk);
    #1;
    start = 1'b1;
    bus   = '1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("isolate");
    check_fall("isolate");

    // Back-to-back: second start lands in the cycle after done
    tick_delay = 2;
    send_start(tbl[2].bus, tbl[2].chk);
    wait_done("b2b_a");
    send_start(tbl[4].bus, 8'h81);
    wait_done("b2b_b");
    // start raised during the DONE cycle must be ignored
    start = 1'b1;
    bus   = '1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_start_write", tx_write, 0);
      check("done_start_busy", busy, 0);
    end

    // Reset mid-frame, then a clean frame
    tick_delay = 4;
    send_start(tbl[2].bus, tbl[2].chk);
    begin
      bit reached = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        if (writes >= 51) begin
          reached = 1'b1;
          break;
        end
      end
      check("mid_reset_reached", reached, 1);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_tx_write", tx_write, 0);
    check("mid_rst_tx_bus", tx_bus, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_idle", tx_write, 0);
    send_start(tbl[0].bus, 8'h00);
    wait_done("post_rst");
    check_fall("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/debug_frame_tx.md
# debug_frame_tx

Transmit half of the debug link. On a `start` request it captures the full 1376-bit datapath snapshot and sends it to the UART transmitter as a framed byte stream: a header byte, 172 data bytes and an XOR checksum byte. It sits between the debug controller, which issues `start` after each step or halt, and the UART TX core, which it drives via `tx_write`/`tx_bus` and paces with `tx_done_tick`.

## Interface
- `DATA_W`, 1376: snapshot width in bits; must be a multiple of 8.
- `N_BYTES`, `DATA_W/8` (172): data bytes per frame.
- `HEADER`, 8'hA5: frame start byte.
- `clk` input 1: single system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state and outputs.
- `start` input 1: one-cycle request to capture and send a frame; honoured only in IDLE.
- `DataPath_bus` input `DATA_W`: datapath snapshot; sampled only on the accepting `start` edge.
- `tx_done_tick` input 1: UART TX finished the current byte; one-cycle pulse.
- `tx_write` output 1: one-cycle pulse; `tx_bus` is valid in the same cycle.
- `tx_bus` output 8: registered byte to transmit.
- `busy` output 1: high from the cycle after an accepted `start` through the DONE cycle.
- `done` output 1: one-cycle pulse when the frame is complete.

## Operation
- Reset values:
  - outputs: `tx_write`=0, `tx_bus`=8'h00, `busy`=0, `done`=0.
  - internal: state=IDLE, byte counter=0, checksum=0, snapshot register=0.
- States (one-hot, 5 bits):
  - IDLE: wait for `start`.
  - HDR: send the header byte.
  - DATA: send one data byte.
  - WAIT: wait for the UART to finish the current byte.
  - CHK: send the checksum byte.
  - DONE: signal frame completion.
- Transitions:
  - IDLE: on `start`, latch `DataPath_bus` into the snapshot register, clear the counter and checksum, go to HDR.
  - HDR: pulse `tx_write` with `tx_bus`=`HEADER`, go to WAIT.
  - DATA: pulse `tx_write` with `tx_bus`=snapshot[8*k+7:8*k] for counter k. XOR that byte into the checksum, increment k, go to WAIT.
  - WAIT: on `tx_done_tick`, go to DATA if k<`N_BYTES`, CHK if k==`N_BYTES` and the checksum is unsent, DONE otherwise.
  - CHK: pulse `tx_write` with `tx_bus`=checksum, set the checksum-sent flag, go to WAIT.
  - DONE: pulse `done`, go to IDLE.
- Byte order: LSB byte first; byte 0 is bits [7:0], byte 171 is bits [1375:1368].
- Checksum: XOR of the 172 data bytes only; the header is excluded.
- Counter: 8 bits, range 0..172, never wraps.
- Boundary conditions:
  - `start` while busy: ignored; no re-capture.
  - `start` in DONE: ignored.
  - `tx_done_tick` outside WAIT, including the same cycle as `tx_write`: ignored.
  - `reset` mid-frame: immediate return to IDLE with outputs at reset values. A byte already handed to the UART may still complete, and its trailing `tx_done_tick` is ignored.
  - Changes on `DataPath_bus` after capture do not affect the frame.

## Timing
- Capture happens on the `start` edge (cycle 0).
- First `tx_write` (header) is in cycle 1; `busy` rises in cycle 1.
- Each subsequent `tx_write` is exactly 1 cycle after the `tx_done_tick` that closes the previous byte.
- A frame is 174 `tx_write` pulses.
- `done` is 1 cycle after the 174th `tx_done_tick`; `busy` falls the cycle after `done`.
- A new `start` is accepted from the cycle after `done`.
- Minimum frame length with an ideal UART (tick one cycle after write) is 1 + 174×2 + 1 = 350 cycles.

## Structure
- Shared package `debug_pkg` holds:
  - `HEADER` value;
  - state one-hot encodings (`ST_IDLE`, `ST_HDR`, `ST_DATA`, `ST_WAIT`, `ST_CHK`, `ST_DONE`);
  - `DATA_W`/`N_BYTES` constants, shared with the debug controller.
- No sub-module. Byte selection is an indexed part-select of the snapshot register; a shifting register is an acceptable alternative if byte order is preserved.

## Test plan
- Reset, then `start` with `DataPath_bus` = byte i holding i (0..171). Expect tx_bus sequence A5, 00, 01, …, AB, then checksum. Expect `done` after the 174th tick.
- All-ones bus. Expect 172 bytes of FF and checksum 00 (an even count of FF bytes).
- Bus changed to 0 the cycle after `start`, plus a second `start` mid-frame. Expect the frame still carries the original data and the second `start` is ignored.
- Model the UART with a 10-cycle tick delay, and inject a stray `tx_done_tick` in IDLE and in the `tx_write` cycle. Expect no extra bytes and exactly 174 writes.
- Assert `reset` after byte 50. Expect all outputs 0 next cycle, then a full clean frame on the next `start`.
- Back-to-back frames: `start` in the cycle after `done`. Expect acceptance and header A5 one cycle later.
